// File: rtl/mul_div_unit.sv
// Sequential signed multiply/divide unit: one shift-add or restoring-divide step per clock.
// Optional macro MULDIV_UNSIGNED_EN enables the unsigned MULU (op 10) and DIVU (op 11) encodings.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, INIT, RUN, FINISH} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q, m_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q, rneg_q;
  logic [WIDTH-1:0]   z_hi_q, z_lo_q;
  logic               done_q, dz_q;

  logic               uns, is_div, sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     trial, sum;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

`ifdef MULDIV_UNSIGNED_EN
  assign uns = op_q[1];
`else
  logic unused_op_hi;
  assign uns          = 1'b0;
  assign unused_op_hi = op_q[1];
`endif

  assign is_div = op_q[0];

  always_comb begin
    sgn_a = ~uns & a_q[WIDTH-1];
    sgn_b = ~uns & b_q[WIDTH-1];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    mag_a = cond_neg(a_q, sgn_a);
    mag_b = cond_neg(b_q, sgn_b);
    trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, m_q};
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
  end

  always_ff @(posedge clock) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = INIT;
      INIT:    state_d = RUN;
      RUN:     if (cnt_q == CNT_W'(WIDTH-1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  // Operand capture and iteration datapath; no reset, always reloaded before use
  always_ff @(posedge clock) begin
    case (state_q)
      IDLE: if (start) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
      end
      INIT: begin
        hi_q   <= '0;
        lo_q   <= is_div ? mag_a : mag_b;
        m_q    <= is_div ? mag_b : mag_a;
        neg_q  <= sgn_a ^ sgn_b;
        rneg_q <= sgn_a;
        cnt_q  <= '0;
      end
      RUN: begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (is_div) begin
          if (!trial[WIDTH]) begin
            hi_q <= trial[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_q <= {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
            lo_q <= {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          hi_q <= sum[WIDTH:1];
          lo_q <= {sum[0], lo_q[WIDTH-1:1]};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      z_hi_q <= '0;
      z_lo_q <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == FINISH) begin
        done_q <= 1'b1;
        if (is_div && (b_q == '0)) begin
          z_hi_q <= a_q;
          z_lo_q <= '1;
          dz_q   <= 1'b1;
        end else if (is_div) begin
          z_hi_q <= cond_neg(hi_q, rneg_q);
          z_lo_q <= cond_neg(lo_q, neg_q);
          dz_q   <= 1'b0;
        end else begin
          {z_hi_q, z_lo_q} <= cond_neg2({hi_q, lo_q}, neg_q);
          dz_q             <= 1'b0;
        end
      end
    end
  end

  assign done     = done_q;
  assign z_hi     = z_hi_q;
  assign z_lo     = z_lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected results, a monitor pops on done.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] z_hi, z_lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           done_cnt = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  mul_div_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .z_hi(z_hi), .z_lo(z_lo), .div_zero(div_zero)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("z_hi", 64'(z_hi), 64'(e.hi));
        chk("z_lo", 64'(z_lo), 64'(e.lo));
        chk("div_zero", 64'(div_zero), 64'(e.dz));
        chk("latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                        input bit b2b, input bit extra_start);
    exp_t e;
    int   nb;
    bit   seen;
    if (!b2b) @(negedge clock);
    start = 1'b1; op = o; a = av; b = bv;
    e.hi = ehi; e.lo = elo; e.dz = edz; e.due = cyc + 35;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    chk("hold_hi", 64'(z_hi), 64'(last_hi));
    chk("hold_lo", 64'(z_lo), 64'(last_lo));
    nb = 0; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        if (busy === 1'b1) nb++;
        start = (extra_start && i == 5);
        @(negedge clock);
      end
    end
    start = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    chk("busy_cycles", 64'(nb), 64'd34);
    if (!seen) sb.delete();
    last_hi = ehi; last_lo = elo;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int d0;
    clear = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_z_hi", 64'(z_hi), 64'd0);
    chk("rst_z_lo", 64'(z_lo), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    clear = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0);
    run_op(2'b01, -32'sd17, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op(2'b01, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op(2'b00, 32'd2, 32'd3, 32'h0, 32'h6, 1'b0, 1'b0, 1'b1);
    run_op(2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 1'b0);
    run_op(2'b01, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0);

    // Abort mid-RUN: extra start ignored, clear discards everything, no done follows
    @(negedge clock);
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    start = 1'b1; a = 32'd9;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    chk("clr_z_hi", 64'(z_hi), 64'd0);
    chk("clr_z_lo", 64'(z_lo), 64'd0);
    chk("clr_dz", 64'(div_zero), 64'd0);
    d0 = done_cnt;
    repeat (45) @(negedge clock);
    chk("no_done_after_clear", 64'(done_cnt - d0), 64'd0);
    last_hi = '0; last_lo = '0;

    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef MULDIV_UNSIGNED_EN
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0, 1'b0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op(2'b11, 32'hAB, 32'h0, 32'hAB, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
`else
    run_op(2'b10, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0);
    run_op(2'b11, -32'sd17, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
`endif
    repeat (3) @(negedge clock);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
